// File: rtl/camera_pattern_gen.sv
// Synthetic OV7670-style camera source: VSYNC/HREF/PCLK plus RGB565 test patterns,
// two bytes per pixel (low byte first), all timing counted in PCLK periods.
module camera_pattern_gen #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int VS_LEN = 8,
    parameter int VBP    = 16,
    parameter int HBP    = 8,
    parameter int VFP    = 16
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [1:0]  MODE,
    input  logic [15:0] COLOR,
    output logic        PCLK,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  DATA,
    output logic [7:0]  FRAME_CNT,
    output logic        FRAME_DONE,
    output logic        BUSY
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [15:0]   VS_LAST   = 16'(VS_LEN - 1);
    localparam logic [15:0]   VBP_LAST  = 16'(VBP - 1);
    localparam logic [15:0]   LINE_LAST = 16'(2 * WIDTH - 1);
    localparam logic [15:0]   HBP_LAST  = 16'(HBP - 1);
    localparam logic [15:0]   VFP_LAST  = 16'(VFP - 1);
    localparam logic [15:0]   HALF_X    = 16'(WIDTH / 2);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        BACK,
        LINE,
        GAP,
        FRONT
    } state_t;

    state_t        state;
    logic [15:0]   cnt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hi_byte;
    logic [1:0]    mode_q;
    logic [15:0]   color_q;

    logic [15:0]   cur_pix;
    logic [15:0]   next_y;
    logic [15:0]   line_start_pix;

    function automatic logic [15:0] pixel(input logic [15:0] xv, input logic [15:0] yv,
                                          input logic [1:0] m, input logic [15:0] c);
        logic [15:0] p;
        case (m)
            2'd0:    p = c;
            2'd1:    p = (xv < HALF_X) ? 16'hF800 : 16'h001F;
            2'd2:    p = yv[3] ? 16'h07E0 : 16'h0000;
            default: p = (xv == yv) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    // First byte of a line is needed one tick early, so its pixel uses the upcoming y.
    always_comb begin
        cur_pix        = pixel(16'(x), 16'(y), mode_q, color_q);
        next_y         = (state == BACK) ? 16'd0 : 16'(y) + 16'd1;
        line_start_pix = pixel(16'd0, next_y, mode_q, color_q);
    end

    // Everything except PCLK advances only on the edge where PCLK falls (PCLK==1 now).
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            x          <= '0;
            y          <= '0;
            hi_byte    <= 1'b0;
            mode_q     <= 2'd0;
            color_q    <= 16'd0;
            PCLK       <= 1'b0;
            VSYNC      <= 1'b0;
            HREF       <= 1'b0;
            DATA       <= 8'd0;
            FRAME_CNT  <= 8'd0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            PCLK       <= ~PCLK;
            FRAME_DONE <= 1'b0;
            if (PCLK) begin
                case (state)
                    IDLE: begin
                        if (ENABLE) begin
                            state   <= SYNC;
                            cnt     <= 16'd0;
                            mode_q  <= MODE;
                            color_q <= COLOR;
                            VSYNC   <= 1'b1;
                            BUSY    <= 1'b1;
                        end
                    end
                    SYNC: begin
                        if (cnt == VS_LAST) begin
                            state <= BACK;
                            cnt   <= 16'd0;
                            VSYNC <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    BACK: begin
                        if (cnt == VBP_LAST) begin
                            state   <= LINE;
                            cnt     <= 16'd0;
                            x       <= '0;
                            y       <= '0;
                            hi_byte <= 1'b1;
                            HREF    <= 1'b1;
                            DATA    <= line_start_pix[7:0];
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    LINE: begin
                        if (cnt == LINE_LAST) begin
                            state <= GAP;
                            cnt   <= 16'd0;
                            x     <= '0;
                            HREF  <= 1'b0;
                            DATA  <= 8'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                            if (hi_byte) begin
                                DATA    <= cur_pix[15:8];
                                x       <= x + 1'b1;
                                hi_byte <= 1'b0;
                            end else begin
                                DATA    <= cur_pix[7:0];
                                hi_byte <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (cnt == HBP_LAST) begin
                            cnt <= 16'd0;
                            if (y < Y_LAST) begin
                                state   <= LINE;
                                y       <= y + 1'b1;
                                hi_byte <= 1'b1;
                                HREF    <= 1'b1;
                                DATA    <= line_start_pix[7:0];
                            end else begin
                                state <= FRONT;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    FRONT: begin
                        if (cnt == VFP_LAST) begin
                            cnt        <= 16'd0;
                            FRAME_DONE <= 1'b1;
                            FRAME_CNT  <= FRAME_CNT + 8'd1;
                            if (ENABLE) begin
                                state   <= SYNC;
                                mode_q  <= MODE;
                                color_q <= COLOR;
                                VSYNC   <= 1'b1;
                            end else begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Scoreboard bench for camera_pattern_gen: stimulus queues expected bytes and frame
// records, an independent monitor pops and compares whatever the DUT presents.
module tb_camera_pattern_gen;

    localparam int W   = 5;
    localparam int H   = 9;
    localparam int VSL = 3;
    localparam int VB  = 2;
    localparam int HB  = 1;
    localparam int VF  = 2;
    localparam int FRAME_PCLK = VSL + VB + H * (2 * W + HB) + VF;
    localparam int FRAME_CLK  = 2 * FRAME_PCLK;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic [1:0]  MODE = 2'd0;
    logic [15:0] COLOR = 16'd0;
    logic        PCLK;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  DATA;
    logic [7:0]  FRAME_CNT;
    logic        FRAME_DONE;
    logic        BUSY;

    camera_pattern_gen #(
        .WIDTH(W), .HEIGHT(H), .VS_LEN(VSL), .VBP(VB), .HBP(HB), .VFP(VF)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .MODE(MODE), .COLOR(COLOR),
        .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA), .FRAME_CNT(FRAME_CNT),
        .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [7:0] b;
        int         x;
        int         y;
    } byteExp_t;

    byteExp_t    byteQ[$];
    logic [7:0]  frameQ[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    logic [7:0]  expFrameCnt = 8'd0;
    logic [1:0]  curMode = 2'd0;
    logic [15:0] curColor = 16'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] expPixel(input logic [1:0] m, input logic [15:0] c, input int px, input int py);
        case (m)
            2'd0:    return c;
            2'd1:    return (px < W / 2) ? 16'hF800 : 16'h001F;
            2'd2:    return ((py / 8) % 2 == 1) ? 16'h07E0 : 16'h0000;
            default: return (px == py) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic pushFrame(input logic [1:0] m, input logic [15:0] c);
        byteExp_t    e;
        logic [15:0] p;
        for (int py = 0; py < H; py++) begin
            for (int px = 0; px < W; px++) begin
                p = expPixel(m, c, px, py);
                e.x = px;
                e.y = py;
                e.b = p[7:0];
                byteQ.push_back(e);
                e.b = p[15:8];
                byteQ.push_back(e);
            end
        end
        expFrameCnt = expFrameCnt + 8'd1;
        frameQ.push_back(expFrameCnt);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return VSYNC;
            1:       return FRAME_DONE;
            default: return HREF;
        endcase
    endfunction

    task automatic waitEvent(input int sel, input int budget, input string name, output logic found);
        logic prev;
        logic now;
        found = 1'b0;
        prev  = sig(sel);
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge CLOCK);
            now = sig(sel);
            if (now && !prev) found = 1'b1;
            prev = now;
        end
        checkOutput({"wait_", name}, found, 1);
    endtask

    // Monitor: frame-level checks run before the VSYNC-rise bookkeeping because
    // back-to-back frames restart VSYNC on the same edge that FRAME_DONE fires.
    int       vsRiseCycle = 0;
    int       vsPclks = 0;
    int       lines = 0;
    int       lineBytes = 0;
    logic     vsPrev = 1'b0;
    logic     hrefPrev = 1'b0;
    logic     fdPrev = 1'b0;

    always @(negedge CLOCK) begin
        byteExp_t   e;
        logic [7:0] fc;
        cycle++;
        if (!RESET_N) begin
            vsPrev    = 1'b0;
            hrefPrev  = 1'b0;
            fdPrev    = 1'b0;
            lineBytes = 0;
            lines     = 0;
            vsPclks   = 0;
        end else begin
            if (FRAME_DONE) begin
                checkOutput("frame_done_single", fdPrev, 0);
                checkOutput("frame_expected", frameQ.size() > 0, 1);
                if (frameQ.size() > 0) begin
                    fc = frameQ.pop_front();
                    checkOutput("frame_cnt", FRAME_CNT, fc);
                end
                checkOutput("frame_lines", lines, H);
                checkOutput("vsync_pclks", vsPclks, VSL);
                checkOutput("frame_length", cycle - vsRiseCycle, FRAME_CLK);
            end
            if (VSYNC && !vsPrev) begin
                vsRiseCycle = cycle;
                vsPclks     = 0;
                lines       = 0;
            end
            if (PCLK) begin
                if (VSYNC) vsPclks++;
                if (HREF) begin
                    if (!hrefPrev) begin
                        lines++;
                        lineBytes = 0;
                    end
                    lineBytes++;
                    checkOutput("byte_available", byteQ.size() > 0, 1);
                    if (byteQ.size() > 0) begin
                        e = byteQ.pop_front();
                        checkOutput($sformatf("pixel_byte(x=%0d,y=%0d)", e.x, e.y), DATA, e.b);
                    end
                end else begin
                    if (hrefPrev) checkOutput("line_bytes", lineBytes, 2 * W);
                    checkOutput("data_idle_zero", DATA, 0);
                end
                hrefPrev = HREF;
            end
            vsPrev = VSYNC;
            fdPrev = FRAME_DONE;
        end
    end

    initial begin
        #(95000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus();
        logic found;
        logic expP;
        logic sawVs;
        int   n;

        // Reset: everything held at zero, PCLK static.
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        repeat (4) begin
            @(negedge CLOCK);
            checkOutput("reset_pclk", PCLK, 0);
        end
        checkOutput("reset_vsync", VSYNC, 0);
        checkOutput("reset_href", HREF, 0);
        checkOutput("reset_data", DATA, 0);
        checkOutput("reset_frame_cnt", FRAME_CNT, 0);
        checkOutput("reset_frame_done", FRAME_DONE, 0);
        checkOutput("reset_busy", BUSY, 0);

        RESET_N = 1'b1;
        expP = 1'b1;
        repeat (6) begin
            @(negedge CLOCK);
            checkOutput("idle_pclk_toggle", PCLK, expP);
            checkOutput("idle_vsync", VSYNC, 0);
            checkOutput("idle_href", HREF, 0);
            checkOutput("idle_busy", BUSY, 0);
            expP = ~expP;
        end

        // Frame A: solid colour; MODE/COLOR are changed mid-frame and must be ignored.
        MODE = 2'd0;  COLOR = 16'h1234;  curMode = 2'd0;  curColor = 16'h1234;
        ENABLE = 1'b1;
        n = 0;
        while (!VSYNC && n < 4) begin
            @(negedge CLOCK);
            n++;
        end
        checkOutput("first_vsync_latency_ok", (n >= 1 && n <= 2) ? 1 : 0, 1);
        pushFrame(curMode, curColor);
        checkOutput("busy_in_frame", BUSY, 1);
        @(negedge CLOCK);
        MODE = 2'd1;  COLOR = 16'hBEEF;  curMode = 2'd1;  curColor = 16'hBEEF;

        // Frames B and C run back to back with the next pattern queued mid-frame.
        for (int f = 0; f < 2; f++) begin
            waitEvent(0, FRAME_CLK + 10, "vsync_bc", found);
            if (found) pushFrame(curMode, curColor);
            MODE = curMode + 2'd1;
            curMode = curMode + 2'd1;
        end

        // Frame D: diagonal pattern, ENABLE dropped during line 5.
        waitEvent(0, FRAME_CLK + 10, "vsync_d", found);
        if (found) pushFrame(curMode, curColor);
        repeat (6) waitEvent(2, FRAME_CLK, "href_line5", found);
        repeat (3) @(negedge CLOCK);
        ENABLE = 1'b0;
        MODE   = 2'd0;
        waitEvent(1, FRAME_CLK, "frame_done_d", found);
        @(negedge CLOCK);
        checkOutput("busy_after_disable", BUSY, 0);
        sawVs = 1'b0;
        repeat (2 * FRAME_CLK) begin
            @(negedge CLOCK);
            sawVs = sawVs | VSYNC;
        end
        checkOutput("no_vsync_after_disable", sawVs, 0);
        checkOutput("frame_cnt_after_d", FRAME_CNT, 4);

        // Frame E: reset asserted mid-line 7 aborts the frame.
        MODE = 2'd0;  COLOR = 16'h5A3C;  curMode = 2'd0;  curColor = 16'h5A3C;
        ENABLE = 1'b1;
        waitEvent(0, 10, "vsync_e", found);
        if (found) pushFrame(curMode, curColor);
        repeat (8) waitEvent(2, FRAME_CLK, "href_line7", found);
        repeat (3) @(negedge CLOCK);
        while (PCLK) @(negedge CLOCK);
        RESET_N = 1'b0;
        byteQ.delete();
        frameQ.delete();
        expFrameCnt = 8'd0;
        @(negedge CLOCK);
        checkOutput("abort_href", HREF, 0);
        checkOutput("abort_data", DATA, 0);
        checkOutput("abort_frame_cnt", FRAME_CNT, 0);
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_frame_done", FRAME_DONE, 0);
        @(negedge CLOCK);

        // 256 back-to-back frames cycling through every mode; FRAME_CNT wraps to 0.
        curMode = 2'd0;  curColor = 16'h0007;
        MODE = curMode;  COLOR = curColor;
        RESET_N = 1'b1;
        for (int i = 0; i < 256; i++) begin
            waitEvent(0, FRAME_CLK + 10, "vsync_wrap", found);
            if (!found) break;
            pushFrame(curMode, curColor);
            if (i == 255) begin
                ENABLE = 1'b0;
            end else begin
                curMode  = 2'((i + 1) % 4);
                curColor = 16'((i + 1) * 4099 + 7);
                MODE     = curMode;
                COLOR    = curColor;
            end
        end
        waitEvent(1, FRAME_CLK + 10, "frame_done_wrap", found);
        @(negedge CLOCK);
        checkOutput("frame_cnt_wrap", FRAME_CNT, 0);
        checkOutput("busy_after_wrap", BUSY, 0);

        repeat (4) @(negedge CLOCK);
        checkOutput("bytes_left", byteQ.size(), 0);
        checkOutput("frames_left", frameQ.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
